// File: rtl/mul_iter_seq_if.sv
// Operand/product handshake bundle for mul_iter_seq.
//   in_valid/in_ready/a/b        : operand pair channel (master -> slave)
//   out_valid/out_ready/p        : product channel (slave -> master)
//   busy                         : sequencer is in CALC or DONE
interface mul_iter_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;
    logic                 busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/mul_iter_seq.sv
// Iterative WIDTH x WIDTH unsigned multiplier that time-multiplexes one
// external combinational 4x4 multiplier over all digit pairs.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : operand/product valid-ready handshake, busy flag
//   mul_a, mul_b    : digits driven to the shared 4x4 multiplier
//   mul_c           : 8-bit product returned by the shared multiplier
module mul_iter_seq #(
    parameter int unsigned WIDTH      = 16,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mul_iter_seq_if.slave       bus,
    output logic [3:0]          mul_a,
    output logic [3:0]          mul_b,
    input  logic [7:0]          mul_c
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   ra_q;
    logic [WIDTH-1:0]   rb_q;
    logic [PW-1:0]      acc_q;
    logic [PW-1:0]      p_q;
    logic [CW-1:0]      i_q;
    logic [CW-1:0]      j_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [CW:0]        sum_ij;
    logic [PW-1:0]      term;
    logic               i_last;
    logic               j_last;
    logic               zero_op;

    // Digit pair for the shared multiplier; held at zero outside CALC.
    always_comb begin
        mul_a = 4'd0;
        mul_b = 4'd0;
        if (state_q == CALC) begin
            mul_a = ra_q[{i_q, 2'b00} +: 4];
            mul_b = rb_q[{j_q, 2'b00} +: 4];
        end
    end

    // Partial product weighted by 16^(i+j).
    assign sum_ij  = {1'b0, i_q} + {1'b0, j_q};
    assign term    = PW'(mul_c) << {sum_ij, 2'b00};
    assign i_last  = (i_q == CW'(N - 1));
    assign j_last  = (j_q == CW'(N - 1));
    assign zero_op = EARLY_ZERO && ((bus.a == '0) || (bus.b == '0));

    // Sequencer: accept, walk digit pairs (j inner, i outer), hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            rb_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        ra_q       <= bus.a;
                        rb_q       <= bus.b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (zero_op) begin
                            p_q         <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_q + term;
                    if (j_last) begin
                        j_q <= '0;
                        if (i_last) begin
                            i_q         <= '0;
                            p_q         <= acc_q + term;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            i_q <= i_q + CW'(1);
                        end
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;
endmodule
